// File: rtl/sonic_avst_pkt_gen_if.sv
// Avalon-ST source bus carried from the packet generator to its sink.
// The master modport is the packet source; the slave modport is the sink.
interface sonic_avst_pkt_gen_if #(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3
);
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_startofpacket;
  logic               out_endofpacket;
  logic [EMPTY_W-1:0] out_empty;
  logic               out_ready;

  modport master (
    output out_data,
    output out_valid,
    output out_startofpacket,
    output out_endofpacket,
    output out_empty,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_startofpacket,
    input  out_endofpacket,
    input  out_empty,
    output out_ready
  );
endinterface

// File: rtl/sonic_avst_pkt_gen.sv
// Avalon-ST packet generator: fixed-length packets with a counting payload and idle gaps.
// Define SONIC_PKTGEN_SEQ_EN to place the 32-bit packet number in the first payload bytes.
module sonic_avst_pkt_gen #(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3,
  parameter int LEN_W   = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_W-1:0]     pkt_len,
  input  logic [15:0]          pkt_count,
  input  logic [7:0]           gap_cycles,
  sonic_avst_pkt_gen_if.master src,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          pkts_sent
);

  localparam int SYM = DATA_W / 8;
`ifdef SONIC_PKTGEN_SEQ_EN
  localparam int SEQ_W = 32;
  localparam int OFF_W = LEN_W;
`else
  localparam int SEQ_W = 8;
  localparam int OFF_W = 8;
`endif

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state, next_state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   rem_q;
  logic [LEN_W-1:0]   len_eff;
  logic [15:0]        left_q;
  logic               cont_q;
  logic [7:0]         gap_q;
  logic [7:0]         gap_cnt;
  logic [SEQ_W-1:0]   seq_q;
  logic               stop_pend;
  logic               beat_acc;
  logic               last_beat;
  logic               eop_acc;
  logic               more_pkts;
  logic               stop_now;
  logic [OFF_W-1:0]   beat_off;

  logic [DATA_W-1:0]  data_c;
  logic               sop_c;
  logic               eop_c;
  logic [EMPTY_W-1:0] empty_c;

  // rem_q counts bytes still to send including the beat on the bus.
  assign len_eff   = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
  assign last_beat = (rem_q <= LEN_W'(SYM));
  assign beat_acc  = (state == SEND) && src.out_ready;
  assign eop_acc   = beat_acc && last_beat;
  assign more_pkts = cont_q || (left_q != 16'd1);
  assign stop_now  = stop_pend || stop;
  assign beat_off  = OFF_W'(len_q - rem_q);
  assign busy      = (state != IDLE);

`ifdef SONIC_PKTGEN_SEQ_EN
  function automatic logic [7:0] payload_byte(input logic [31:0] s, input logic [LEN_W-1:0] idx);
    logic [7:0] b;
    b = s[7:0] + idx[7:0];
    if (idx < LEN_W'(4)) begin
      case (idx[1:0])
        2'd0:    b = s[31:24];
        2'd1:    b = s[23:16];
        2'd2:    b = s[15:8];
        default: b = s[7:0];
      endcase
    end
    return b;
  endfunction
`else
  function automatic logic [7:0] payload_byte(input logic [7:0] s, input logic [7:0] idx);
    return s + idx;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = SEND;
      SEND: begin
        if (eop_acc) begin
          if (stop_now || !more_pkts) next_state = IDLE;
          else if (gap_q == 8'd0)     next_state = SEND;
          else                        next_state = GAP;
        end
      end
      GAP: begin
        if (stop_now)               next_state = IDLE;
        else if (gap_cnt == 8'd1)   next_state = SEND;
      end
      default: next_state = IDLE;
    endcase
  end

  // A stop seen while running is held until the current packet finishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q     <= '0;
      rem_q     <= '0;
      left_q    <= '0;
      cont_q    <= 1'b0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      seq_q     <= '0;
      stop_pend <= 1'b0;
      pkts_sent <= '0;
      done      <= 1'b0;
    end else begin
      done      <= (state != IDLE) && (next_state == IDLE);
      stop_pend <= (state != IDLE) && (next_state != IDLE) && stop_now;
      if ((state == IDLE) && start) begin
        len_q  <= len_eff;
        rem_q  <= len_eff;
        left_q <= pkt_count;
        cont_q <= (pkt_count == 16'd0);
        gap_q  <= gap_cycles;
        seq_q  <= '0;
      end else if (beat_acc) begin
        if (last_beat) begin
          rem_q     <= len_q;
          seq_q     <= seq_q + 1'b1;
          pkts_sent <= pkts_sent + 32'd1;
          gap_cnt   <= gap_q;
          if (!cont_q) left_q <= left_q - 16'd1;
        end else begin
          rem_q <= rem_q - LEN_W'(SYM);
        end
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
    end
  end

  // Beat contents are a pure function of held state, so a stalled beat stays stable.
  always_comb begin
    data_c  = '0;
    sop_c   = 1'b0;
    eop_c   = 1'b0;
    empty_c = '0;
    if (state == SEND) begin
      sop_c = (rem_q == len_q);
      eop_c = last_beat;
      if (last_beat) empty_c = EMPTY_W'(LEN_W'(SYM) - rem_q);
      for (int k = 0; k < SYM; k++) begin
        if (LEN_W'(k) < rem_q)
          data_c[DATA_W-1-8*k -: 8] = payload_byte(seq_q, beat_off + OFF_W'(k));
      end
    end
  end

  assign src.out_valid         = (state == SEND);
  assign src.out_data          = data_c;
  assign src.out_startofpacket = sop_c;
  assign src.out_endofpacket   = eop_c;
  assign src.out_empty         = empty_c;

endmodule

// File: tb/tb_sonic_avst_pkt_gen.sv
// Randomized self-checking bench for sonic_avst_pkt_gen against a packet-level reference model.
module tb_sonic_avst_pkt_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [13:0] pkt_len;
  logic [15:0] pkt_count;
  logic [7:0]  gap_cycles;
  logic        busy;
  logic        done;
  logic [31:0] pkts_sent;

  int total;
  int bad;

  sonic_avst_pkt_gen_if #(.DATA_W(64), .EMPTY_W(3)) bus ();

  sonic_avst_pkt_gen #(.DATA_W(64), .EMPTY_W(3), .LEN_W(14)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .pkt_len    (pkt_len),
    .pkt_count  (pkt_count),
    .gap_cycles (gap_cycles),
    .src        (bus),
    .busy       (busy),
    .done       (done),
    .pkts_sent  (pkts_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected beat b of packet s for a packet of leff bytes, packed as {data, pad, sop, eop, empty}.
  function automatic logic [79:0] expBeat(input int s, input int leff, input int b);
    logic [63:0] d;
    logic [7:0]  v;
    logic [2:0]  emp;
    logic        sop;
    logic        eop;
    int          nb;
    int          i;
    d  = '0;
    nb = (leff + 7) / 8;
    for (int k = 0; k < 8; k++) begin
      i = b * 8 + k;
      if (i < leff) begin
        v = 8'((s + i) % 256);
`ifdef SONIC_PKTGEN_SEQ_EN
        if (i < 4) v = 8'((s >> (8 * (3 - i))) & 255);
`endif
        d[63-8*k -: 8] = v;
      end
    end
    sop = (b == 0);
    eop = (b == nb - 1);
    emp = eop ? 3'((8 - leff % 8) % 8) : 3'd0;
    return {d, 11'd0, sop, eop, emp};
  endfunction

  function automatic logic [79:0] observed();
    return {bus.out_data, 11'd0, bus.out_startofpacket, bus.out_endofpacket, bus.out_empty};
  endfunction

  // One generation run; readyMode 0=always, 1=toggle, 2=random; stopPkt<0 means no stop.
  task automatic applyStimulus(input int len, input int cnt, input int gap, input int readyMode,
                               input int stopPkt, input bit restartPoke);
    int          leff, nb, expPkts, pktIdx, beatIdx, idle, beats, extra;
    bit          doneSeen, stalled, stopSent, tog, r;
    logic [31:0] base;
    logic [79:0] obs, prevObs;
    leff    = (len == 0) ? 1 : len;
    nb      = (leff + 7) / 8;
    expPkts = (stopPkt >= 0 && (cnt == 0 || stopPkt < cnt)) ? stopPkt + 1 : cnt;
    base    = pkts_sent;
    stop    = 1'b1;
    @(negedge clk);
    stop       = 1'b0;
    pkt_len    = 14'(len);
    pkt_count  = 16'(cnt);
    gap_cycles = 8'(gap);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    pkt_len    = 14'($urandom);
    pkt_count  = 16'($urandom);
    gap_cycles = 8'($urandom);
    checkOutput("first_beat_valid", 80'(bus.out_valid), 80'd1);
    checkOutput("busy_after_start", 80'(busy), 80'd1);
    pktIdx = 0; beatIdx = 0; idle = 0; beats = 0;
    doneSeen = 0; stalled = 0; stopSent = 0; tog = 1;
    prevObs = '0;
    for (int cyc = 0; cyc < 4000 && !doneSeen; cyc++) begin
      start = restartPoke && (cyc == 3);
      obs = observed();
      if (stalled) checkOutput("stall_hold", obs, prevObs);
      if (done) begin
        doneSeen = 1;
        stop = 1'b0;
        checkOutput("busy_at_done", 80'(busy), 80'd0);
        checkOutput("valid_at_done", 80'(bus.out_valid), 80'd0);
      end else if (bus.out_valid) begin
        if (beatIdx == 0 && pktIdx > 0) checkOutput("gap_len", 80'(idle), 80'(gap));
        if (pktIdx < expPkts) checkOutput("beat", obs, expBeat(pktIdx, leff, beatIdx));
        else                  checkOutput("extra_pkt", 80'(pktIdx), 80'(expPkts - 1));
        case (readyMode)
          0:       r = 1'b1;
          1:       r = tog;
          default: r = 1'($urandom_range(0, 1));
        endcase
        tog = ~tog;
        bus.out_ready = r;
        if (!stopSent && pktIdx == stopPkt && beatIdx == ((nb > 1) ? 1 : 0)) begin
          stop = 1'b1;
          stopSent = 1;
        end else begin
          stop = 1'b0;
        end
        if (r) begin
          beats++;
          stalled = 0;
          if (beatIdx == nb - 1) begin
            pktIdx++;
            beatIdx = 0;
            idle = 0;
          end else begin
            beatIdx++;
          end
        end else begin
          stalled = 1;
          prevObs = obs;
        end
      end else begin
        idle++;
        stalled = 0;
        stop = 1'b0;
        tog = ~tog;
        bus.out_ready = 1'($urandom_range(0, 1));
        checkOutput("busy_gap", 80'(busy), 80'd1);
      end
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
    if (!doneSeen) checkOutput("timeout", 80'd0, 80'd1);
    checkOutput("pkts_received", 80'(pktIdx), 80'(expPkts));
    checkOutput("beats_total", 80'(beats), 80'(expPkts * nb));
    checkOutput("pkts_sent", 80'(pkts_sent - base), 80'(expPkts));
    extra = 0;
    repeat (3) begin
      if (done) extra++;
      @(negedge clk);
    end
    checkOutput("done_once", 80'(extra), 80'd0);
    checkOutput("idle_valid", 80'(bus.out_valid), 80'd0);
    bus.out_ready = 1'b1;
  endtask

  task automatic resetMidPacket();
    pkt_len    = 14'd64;
    pkt_count  = 16'd1;
    gap_cycles = 8'd0;
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_beat2", observed(), expBeat(0, 64, 2));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_valid", 80'(bus.out_valid), 80'd0);
    checkOutput("rst_eop", 80'(bus.out_endofpacket), 80'd0);
    checkOutput("rst_pkts_sent", 80'(pkts_sent), 80'd0);
    checkOutput("rst_busy", 80'(busy), 80'd0);
    checkOutput("rst_done", 80'(done), 80'd0);
    @(negedge clk);
    checkOutput("rst_no_done", 80'(done), 80'd0);
    checkOutput("rst_still_idle", 80'(bus.out_valid), 80'd0);
  endtask

  initial begin
    int len, cnt, gap, sp;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    pkt_len    = '0;
    pkt_count  = '0;
    gap_cycles = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_bus", observed(), 80'd0);
    checkOutput("reset_valid", 80'(bus.out_valid), 80'd0);
    checkOutput("reset_busy", 80'(busy), 80'd0);
    checkOutput("reset_done", 80'(done), 80'd0);
    checkOutput("reset_pkts_sent", 80'(pkts_sent), 80'd0);

    applyStimulus(64, 2, 0, 0, -1, 1);
    applyStimulus(13, 1, 0, 0, -1, 0);
    applyStimulus(5, 3, 4, 0, -1, 0);
    applyStimulus(24, 2, 1, 1, -1, 0);
    applyStimulus(0, 2, 2, 2, -1, 0);
    applyStimulus(20, 0, 1, 2, 2, 0);
    applyStimulus(8, 0, 0, 0, 1, 0);
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(1, 40);
      cnt = $urandom_range(1, 3);
      gap = $urandom_range(0, 3);
      sp  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, cnt - 1) : -1;
      applyStimulus(len, cnt, gap, 2, sp, 0);
    end
    resetMidPacket();
    applyStimulus(9, 2, 0, 0, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
